wb_exmem_ctrl: RTL and testbench
================================

WB_EXMEM_CTRL -- requirements
Module: wb_exmem_ctrl

Interface
REQ-001 The block SHALL have parameter DELAYS, default 10: wait cycles before ack (legal 1..255).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10: word memory depth 2^DEPTH_LOG2 x 32 bit.
REQ-003 The block SHALL have port wb_clk_i, in, 1: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port wb_rst_ni, in, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have ports wbs_stb_i, in, 1 and wbs_cyc_i, in, 1: Wishbone strobe and cycle.
REQ-006 The block SHALL have port wbs_we_i, in, 1: 1 = write, 0 = read.
REQ-007 The block SHALL have port wbs_sel_i, in, 4: byte enables; bit n maps to data[8n+7:8n].
REQ-008 The block SHALL have ports wbs_adr_i, in, 32 (byte address) and wbs_dat_i, in, 32 (write data).
REQ-009 The block SHALL have port wbs_ack_o, out, 1: single-cycle acknowledge pulse.
REQ-010 The block SHALL have port wbs_dat_o, out, 32: read data, valid only while wbs_ack_o=1.

Function
REQ-011 Hit SHALL be defined as wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24]==8'h38).
REQ-012 Word index SHALL be wbs_adr_i[DEPTH_LOG2+1:2]; higher bits in [23:DEPTH_LOG2+2] are ignored, so addresses alias (wrap) modulo 2^DEPTH_LOG2 words.
REQ-013 FSM states SHALL be IDLE, WAIT, ACK.
REQ-014 IDLE: on a hit, go to WAIT with the delay counter cleared to 0; otherwise stay in IDLE.
REQ-015 WAIT: the counter SHALL increment each cycle; at DELAYS-1, go to ACK.
REQ-016 ACK: wbs_ack_o SHALL be 1 for exactly this one cycle, then go unconditionally to IDLE. This mandates one IDLE cycle between back-to-back transactions.
REQ-017 Latency: with the request cycle in IDLE counted as cycle 0, wbs_ack_o SHALL be high in cycle DELAYS+1.
REQ-018 A write SHALL update only the bytes selected by wbs_sel_i, committed at the end of the ACK cycle. A write with sel=4'b0000 still acks and changes nothing.
REQ-019 A read SHALL drive the addressed word on wbs_dat_o during the ACK cycle; in all other cycles wbs_dat_o SHALL be 32'h0.
REQ-020 Abort: if wbs_stb_i or wbs_cyc_i drops during WAIT, the FSM SHALL return to IDLE next cycle with no ack and no memory write.
REQ-021 If wbs_adr_i[31:24] changes away from 8'h38 during WAIT, this SHALL be treated as an abort per REQ-020.
REQ-022 Non-hit requests SHALL never produce an ack and SHALL never modify memory.
REQ-023 The address, data, sel and we values used SHALL be those present in the ACK cycle; the master holds them stable per Wishbone classic.
REQ-024 Read-after-write to the same word in consecutive transactions SHALL return the newly written data.

Reset
REQ-025 While wb_rst_ni=0 at a clock edge: FSM to IDLE, counter to 0, wbs_ack_o=0, wbs_dat_o=32'h0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ack and no write.
REQ-027 Memory contents SHALL NOT be cleared by reset; they are undefined after power-up.

Configuration
REQ-028 Macro EXMEM_FAST_WRITE_EN SHALL select write timing.
REQ-029 With EXMEM_FAST_WRITE_EN defined, a write hit in IDLE SHALL go directly to ACK, acking in cycle 1. Reads are unchanged.
REQ-030 Without EXMEM_FAST_WRITE_EN, writes SHALL follow the same DELAYS+1 latency as reads.

Verification
REQ-031 Latency: DELAYS=10, write 0x3800_0010 <= 32'hDEADBEEF, sel=4'hF -> ack in cycle 11, single-cycle pulse. Then read 0x3800_0010 -> ack in cycle 11, dat_o=32'hDEADBEEF, 0 in all other cycles.
REQ-032 Byte enables: word holds 32'h11223344; write 32'hAABBCCDD with sel=4'b0101 -> read returns 32'h11BB33DD.
REQ-033 Aliasing and miss: with DEPTH_LOG2=10, write 0x3800_1004 then read 0x3800_0004 -> same data. Request to 0x3600_0000 held 30 cycles -> no ack, memory unchanged.
REQ-034 Abort and reset: drop stb at cycle 5 of a write -> no ack, old data retained. Assert wb_rst_ni=0 at cycle 3 of a read -> ack stays 0, FSM returns to IDLE.
REQ-035 Back-to-back: two reads with stb held continuously -> acks in cycles 11 and 23 (one IDLE gap between them).
REQ-036 Fast write: with EXMEM_FAST_WRITE_EN defined, a write acks in cycle 1 and a read still acks in cycle 11.

Source files
------------

// File: rtl/wb_exmem_ctrl.sv
// wb_exmem_ctrl: Wishbone classic slave fronting a 2^DEPTH_LOG2 x 32 word memory
// mapped at 0x38xx_xxxx. Every hit is acked after DELAYS wait cycles. The master
// must hold address, data, sel and we stable until ack. Dropping stb or cyc, or
// moving the address off the window, abandons the access.
// Optional macro EXMEM_FAST_WRITE_EN: write hits skip the wait phase and ack in
// the cycle after the request. Reads keep the full latency.
module wb_exmem_ctrl #(
    parameter int DELAYS     = 10,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DELAYS - 1);

    state_t                state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           mem [0:(2**DEPTH_LOG2)-1];

    // Upper window bits above the index and the byte offset only alias.
    logic                  unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:DEPTH_LOG2+2], wbs_adr_i[1:0]};

    assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == 8'h38);
    assign word_idx = wbs_adr_i[DEPTH_LOG2+1:2];

    // State and delay counter registers; reset aborts any access in flight.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: request in IDLE, count out the wait, one ack cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (hit) begin
`ifdef EXMEM_FAST_WRITE_EN
                    state_nxt = wbs_we_i ? ACK : WAIT;
`else
                    state_nxt = WAIT;
`endif
                end
            end
            WAIT: begin
                if (!hit) begin
                    // Strobe, cycle or window lost: abandon without ack.
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ACK;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Byte-masked write committed at the close of the ack cycle. It is
    // suppressed if reset is sampled on that same edge. Memory is never cleared.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && (state == ACK) && wbs_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b])
                    mem[word_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
        end
    end

    // Ack is decoded straight from the state flop. The read mux is forced to
    // zero outside a read ack, so the bus never shows stale data.
    assign wbs_ack_o = (state == ACK);
    assign wbs_dat_o = ((state == ACK) && !wbs_we_i) ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_wb_exmem_ctrl.sv
// Testbench for wb_exmem_ctrl. The driver issues requests and pushes each
// expected ack (cycle and data) into a queue. The data comes from a
// word-array model of the memory. A monitor on the falling edge pops and
// compares whenever ack is seen. Otherwise it checks that the read bus is zero.
module tb_wb_exmem_ctrl;

    localparam int DELAYS     = 10;
    localparam int DEPTH_LOG2 = 10;
`ifdef EXMEM_FAST_WRITE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;

    wb_exmem_ctrl #(.DELAYS(DELAYS), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o)
    );

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    bit          mon_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc_cnt);
        end
    endtask

    // Monitor: consume one expectation per ack; otherwise the read bus must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_ack: got ack at cycle %0d, expected none", cyc_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_ack_cycle"}, 32'(cyc_cnt), 32'(e.cyc));
                    chk({e.name, "_data"}, dat_o, e.dat);
                end
            end else begin
                chk("dat_zero_without_ack", dat_o, 32'h0);
            end
        end
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[DEPTH_LOG2+1:2]);
    endfunction

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    endtask

    task automatic idle(input int n);
        stb = 1'b0; cyc = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one hit transaction (called at posedge+1, which is cycle 0 of it).
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit keep, input string nm);
        exp_t e;
        bit   got;
        int   ix;
        ix     = idx_of(a);
        e.name = nm;
        e.cyc  = cyc_cnt + ((w && FAST) ? 1 : DELAYS + 1);
        if (w) begin
            logic [31:0] old;
            old = ref_mem.exists(ix) ? ref_mem[ix] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (s[b]) old[8*b +: 8] = d[8*b +: 8];
            ref_mem[ix] = old;
            e.dat = 32'h0;
        end else begin
            e.dat = ref_mem.exists(ix) ? ref_mem[ix] : 32'h0;
        end
        exp_q.push_back(e);
        drive(w, a, d, s);
        got = 1'b0;
        for (int i = 0; i < DELAYS + 20 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack, expected ack at cycle %0d", nm, e.cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        if (!keep) begin stb = 1'b0; cyc = 1'b0; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        logic        w;
        logic [3:0]  s;
        bit          k;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_dat", dat_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Latency for a full-word write and its readback.
        issue(1'b1, 32'h3800_0010, 32'hDEADBEEF, 4'hF, 1'b0, "wr_lat");
        idle(1);
        issue(1'b0, 32'h3800_0010, 32'h0, 4'hF, 1'b0, "rd_lat");
        idle(1);

        // Byte enables.
        issue(1'b1, 32'h3800_0020, 32'h11223344, 4'hF, 1'b0, "be_init");
        issue(1'b1, 32'h3800_0020, 32'hAABBCCDD, 4'b0101, 1'b0, "be_wr");
        issue(1'b0, 32'h3800_0020, 32'h0, 4'hF, 1'b0, "be_rd");
        issue(1'b1, 32'h3800_0020, 32'hFFFFFFFF, 4'b0000, 1'b0, "sel0_wr");
        issue(1'b0, 32'h3800_0020, 32'h0, 4'hF, 1'b0, "sel0_rd");

        // Aliasing: 0x1004 and 0x0004 share word 1.
        issue(1'b1, 32'h3800_1004, 32'hCAFEF00D, 4'hF, 1'b0, "alias_wr");
        issue(1'b0, 32'h3800_0004, 32'h0, 4'hF, 1'b0, "alias_rd");

        // Miss held for 30 cycles must neither ack nor write.
        issue(1'b1, 32'h3800_0000, 32'h0BADF00D, 4'hF, 1'b0, "miss_init");
        drive(1'b1, 32'h3600_0000, 32'hFFFFFFFF, 4'hF);
        repeat (30) @(posedge clk);
        #1;
        idle(2);
        issue(1'b0, 32'h3800_0000, 32'h0, 4'hF, 1'b0, "miss_rd");

        // Abort by dropping stb at cycle 5.
        issue(1'b1, 32'h3800_0040, 32'h12345678, 4'hF, 1'b0, "abort_init");
        drive(FAST ? 1'b0 : 1'b1, 32'h3800_0040, 32'h87654321, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        stb = 1'b0;
        idle(2);
        issue(1'b0, 32'h3800_0040, 32'h0, 4'hF, 1'b0, "abort_rd");

        // Abort by moving the address off the window mid-wait.
        drive(FAST ? 1'b0 : 1'b1, 32'h3800_0040, 32'h55555555, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        adr = 32'h3700_0040;
        repeat (DELAYS + 4) @(posedge clk);
        #1;
        idle(2);
        issue(1'b0, 32'h3800_0040, 32'h0, 4'hF, 1'b0, "adr_abort_rd");

        // Reset at cycle 3 of a read.
        drive(1'b0, 32'h3800_0040, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        issue(1'b0, 32'h3800_0040, 32'h0, 4'hF, 1'b0, "post_rst_rd");

        // Back-to-back reads with stb held: acks at cycles 11 and 23.
        issue(1'b0, 32'h3800_0010, 32'h0, 4'hF, 1'b1, "b2b_rd0");
        issue(1'b0, 32'h3800_0020, 32'h0, 4'hF, 1'b0, "b2b_rd1");

        // Fast-write latency (or standard latency when the macro is off).
        issue(1'b1, 32'h3800_0080, 32'h0F0F0F0F, 4'hF, 1'b0, "cfg_wr");
        issue(1'b0, 32'h3800_0080, 32'h0, 4'hF, 1'b0, "cfg_rd");

        // Randomized traffic over 16 words with aliased upper bits.
        for (int i = 0; i < 16; i++)
            issue(1'b1, 32'h3800_0200 + 32'(i * 4), $urandom, 4'hF, 1'b0, "rnd_init");
        for (int i = 0; i < 200; i++) begin
            a = {8'h38, 12'($urandom), 10'(32'h80 + $urandom_range(0, 15)), 2'($urandom)};
            d = $urandom;
            w = 1'($urandom);
            s = 4'($urandom);
            k = ($urandom_range(0, 3) == 0);
            issue(w, a, d, s, k, w ? "rnd_wr" : "rnd_rd");
        end
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
